// File: rtl/geig_pkt_pkg.sv
// Shared definitions for the geiger packet transmitter.
// Build option: define GEIG_PKT_CSUM_EN to append a checksum byte
// (14-byte frames); leave it undefined for 13-byte frames ending at seq.
package geig_pkt_pkg;

    // FSM encoding kept as plain constants so older tools and
    // netlists see stable state codes.
    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE    = 3'd0;
    localparam state_t ST_SYNC    = 3'd1;
    localparam state_t ST_PAYLOAD = 3'd2;
    localparam state_t ST_SEQ     = 3'd3;
`ifdef GEIG_PKT_CSUM_EN
    localparam state_t ST_CSUM    = 3'd4;
`endif

    localparam int PAYLOAD_BYTES = 10;

`ifdef GEIG_PKT_CSUM_EN
    localparam int FRAME_LEN = 14;
`else
    localparam int FRAME_LEN = 13;
`endif

    // XOR of all bytes of an 80-bit payload, MSB byte first.
    function automatic logic [7:0] xor_bytes(input logic [8*PAYLOAD_BYTES-1:0] data);
        logic [7:0] acc;
        acc = 8'h00;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            acc = acc ^ data[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/geig_trig_sync.sv
// Brings the 10 Hz frame-trigger level into the 1 MHz domain and turns
// its rising edge into a single-cycle trigger pulse.
module geig_trig_sync
    import geig_pkt_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic level,
    output logic trig
);

    logic sync1;
    logic sync2;
    logic prev;

    // Two-flop synchronizer followed by a history flop for edge detection.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbour; blocking here would
    // collapse the chain into a single stage.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            prev  <= 1'b0;
        end else begin
            sync1 <= level;
            sync2 <= sync1;
            prev  <= sync2;
        end
    end

    assign trig = sync2 & ~prev;

endmodule

// File: rtl/geig_packet_tx.sv
// Geiger packet transmitter: on each 10 Hz trigger, snapshots the 80-bit
// data stack and streams SYNC0, SYNC1, ten payload bytes (MSB first), a
// sequence byte and, when GEIG_PKT_CSUM_EN is defined, an XOR checksum
// over payload and seq over a valid/ready byte interface.
module geig_packet_tx
    import geig_pkt_pkg::*;
#(
    parameter logic [7:0] SYNC0 = 8'hEB,
    parameter logic [7:0] SYNC1 = 8'h90
)
(
    input  logic        CLK_1MHZ,
    input  logic        RESET,
    input  logic        CLK_10HZ,
    input  logic [79:0] G_DATA_STACK,
    input  logic        TX_READY,
    output logic [7:0]  TX_DATA,
    output logic        TX_VALID,
    output logic        BUSY,
    output logic [7:0]  DROP_CNT
);

    // Byte positions within the frame: 0-1 sync, 2-11 payload, 12 seq, 13 csum.
    localparam logic [3:0] POS_SYNC_LAST    = 4'd1;
    localparam logic [3:0] POS_PAYLOAD_LAST = 4'(1 + PAYLOAD_BYTES);
    localparam logic [3:0] POS_LAST         = 4'(FRAME_LEN - 1);

    state_t      state;
    logic [3:0]  pos;
    logic [79:0] frame_buf;
    logic [7:0]  seq;
    logic [7:0]  drop_cnt;
    logic [7:0]  tx_data_d;
    logic        trig;
    logic        start;
    logic        xfer;
    logic        last_xfer;
`ifdef GEIG_PKT_CSUM_EN
    logic [7:0]  payload_xor;
`endif

    geig_trig_sync u_trig_sync (
        .clk   (CLK_1MHZ),
        .rst_n (RESET),
        .level (CLK_10HZ),
        .trig  (trig)
    );

    assign TX_VALID  = (state != ST_IDLE);
    assign BUSY      = (state != ST_IDLE);
    assign start     = trig & (state == ST_IDLE);
    assign xfer      = TX_VALID & TX_READY;
    assign last_xfer = xfer & (pos == POS_LAST);
    assign DROP_CNT  = drop_cnt;
    assign TX_DATA   = tx_data_d;

    // Frame sequencer: leaves IDLE on a trigger, then steps one byte per
    // accepted transfer and returns to IDLE after the last one.
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            state <= ST_IDLE;
            pos   <= 4'd0;
        end else if (state == ST_IDLE) begin
            if (trig) begin
                state <= ST_SYNC;
                pos   <= 4'd0;
            end
        end else if (xfer) begin
            pos <= pos + 4'd1;
            case (state)
                ST_SYNC:    if (pos == POS_SYNC_LAST)    state <= ST_PAYLOAD;
                ST_PAYLOAD: if (pos == POS_PAYLOAD_LAST) state <= ST_SEQ;
`ifdef GEIG_PKT_CSUM_EN
                ST_SEQ:     state <= ST_CSUM;
                ST_CSUM:    state <= ST_IDLE;
`else
                ST_SEQ:     state <= ST_IDLE;
`endif
                default:    state <= ST_IDLE;
            endcase
        end
    end

    // Frame buffer: snapshot on trigger, shift out one byte per payload
    // transfer so the outgoing byte is always the top of the register.
    // NOTE: this buffer is a plain register, not a RAM, so it takes the
    // async reset like any other flop; inferring a memory here would make
    // the reset clear impossible.
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            frame_buf <= '0;
        end else if (start) begin
            frame_buf <= G_DATA_STACK;
        end else if (xfer && state == ST_PAYLOAD) begin
            frame_buf <= {frame_buf[71:0], 8'h00};
        end
    end

    // Sequence number advances once per completed frame, wrapping naturally.
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            seq <= 8'h00;
        end else if (last_xfer) begin
            seq <= seq + 8'h01;
        end
    end

    // Triggers seen while a frame is in flight (including on its final
    // transfer) are dropped and counted, saturating at 0xFF.
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            drop_cnt <= 8'h00;
        end else if (trig && BUSY && drop_cnt != 8'hFF) begin
            drop_cnt <= drop_cnt + 8'h01;
        end
    end

`ifdef GEIG_PKT_CSUM_EN
    // Payload XOR is fixed at snapshot time; seq is folded in at output.
    always_ff @(posedge CLK_1MHZ or negedge RESET) begin
        if (!RESET) begin
            payload_xor <= 8'h00;
        end else if (start) begin
            payload_xor <= xor_bytes(G_DATA_STACK);
        end
    end
`endif

    // Output byte mux: registers only change on a transfer, so the byte
    // holds naturally while the receiver stalls.
    // NOTE: default assigned first so no path through the case leaves
    // tx_data_d unassigned and infers a latch.
    always_comb begin
        tx_data_d = 8'h00;
        case (state)
            ST_SYNC:    tx_data_d = (pos == 4'd0) ? SYNC0 : SYNC1;
            ST_PAYLOAD: tx_data_d = frame_buf[79:72];
            ST_SEQ:     tx_data_d = seq;
`ifdef GEIG_PKT_CSUM_EN
            ST_CSUM:    tx_data_d = payload_xor ^ seq;
`endif
            default:    tx_data_d = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_geig_packet_tx.sv
// Scoreboard bench for geig_packet_tx: stimulus pushes expected frame
// bytes into a queue, a negedge monitor pops and compares on every
// accepted transfer and checks byte stability during stalls.
module tb_geig_packet_tx;

    logic        CLK_1MHZ = 1'b0;
    logic        RESET = 1'b0;
    logic        CLK_10HZ = 1'b0;
    logic [79:0] G_DATA_STACK = '0;
    logic        TX_READY = 1'b0;
    logic [7:0]  TX_DATA;
    logic        TX_VALID;
    logic        BUSY;
    logic [7:0]  DROP_CNT;

`ifdef GEIG_PKT_CSUM_EN
    localparam int FLEN = 14;
`else
    localparam int FLEN = 13;
`endif

    int n_vec = 0;
    int n_bad = 0;
    int n_byte = 0;
    logic [7:0] exp_q[$];
    logic       stalled = 1'b0;
    logic [7:0] held = 8'h00;

    geig_packet_tx dut (
        .CLK_1MHZ     (CLK_1MHZ),
        .RESET        (RESET),
        .CLK_10HZ     (CLK_10HZ),
        .G_DATA_STACK (G_DATA_STACK),
        .TX_READY     (TX_READY),
        .TX_DATA      (TX_DATA),
        .TX_VALID     (TX_VALID),
        .BUSY         (BUSY),
        .DROP_CNT     (DROP_CNT)
    );

    always #5 CLK_1MHZ = ~CLK_1MHZ;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: compares every accepted byte against the scoreboard.
    always @(negedge CLK_1MHZ) begin
        if (!RESET) begin
            stalled <= 1'b0;
        end else begin
            if (TX_VALID && stalled)
                check("hold during stall", TX_DATA, held);
            if (TX_VALID && TX_READY) begin
                n_byte++;
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_bad++;
                    $display("FAIL unexpected byte: got %0h expected none", TX_DATA);
                end else begin
                    check($sformatf("byte %0d", n_byte), TX_DATA, exp_q.pop_front());
                end
            end
            stalled <= TX_VALID && !TX_READY;
            held    <= TX_DATA;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge CLK_1MHZ);
        #1;
    endtask

    task automatic raise_10hz();
        cyc(1);
        CLK_10HZ = 1'b1;
    endtask

    task automatic lower_10hz();
        cyc(1);
        CLK_10HZ = 1'b0;
    endtask

    task automatic push_frame(input logic [79:0] d, input logic [7:0] s);
        logic [7:0] x;
        x = s;
        exp_q.push_back(8'hEB);
        exp_q.push_back(8'h90);
        for (int i = 0; i < 10; i++) begin
            exp_q.push_back(d[79-8*i -: 8]);
            x = x ^ d[79-8*i -: 8];
        end
        exp_q.push_back(s);
`ifdef GEIG_PKT_CSUM_EN
        exp_q.push_back(x);
`endif
    endtask

    task automatic wait_valid(input string name);
        for (int i = 0; i < 50 && !TX_VALID; i++) @(negedge CLK_1MHZ);
        check(name, TX_VALID, 1'b1);
    endtask

    task automatic wait_idle(input string name);
        for (int i = 0; i < 400 && (BUSY || exp_q.size() != 0); i++) @(negedge CLK_1MHZ);
        check({name, " busy"}, BUSY, 1'b0);
        check({name, " pending"}, exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic       pat [6] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1};
        logic [79:0] d1;
        logic [79:0] d2;
        logic [7:0]  b;
        int          nv;
        int          nx;

        // Reset held with trigger toggling: everything quiet.
        for (int i = 0; i < 4; i++) begin
            CLK_10HZ = ~CLK_10HZ;
            cyc(2);
            @(negedge CLK_1MHZ);
            check("rst valid", TX_VALID, 1'b0);
            check("rst busy", BUSY, 1'b0);
            check("rst data", TX_DATA, 8'h00);
            check("rst drop", DROP_CNT, 8'h00);
        end
        CLK_10HZ = 1'b0;
        cyc(1);
        RESET = 1'b1;
        cyc(4);
        check("idle after release", TX_VALID, 1'b0);

        // Nominal frame, receiver always ready.
        G_DATA_STACK = 80'h0123456789ABCDEF0011;
        TX_READY = 1'b1;
        foreach (exp_q[i]) ;
        exp_q.push_back(8'hEB); exp_q.push_back(8'h90);
        exp_q.push_back(8'h01); exp_q.push_back(8'h23); exp_q.push_back(8'h45);
        exp_q.push_back(8'h67); exp_q.push_back(8'h89); exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hEF); exp_q.push_back(8'h00);
        exp_q.push_back(8'h11); exp_q.push_back(8'h00);
`ifdef GEIG_PKT_CSUM_EN
        exp_q.push_back(8'h11);
`endif
        raise_10hz();
        wait_valid("nom start");
        nv = 0;
        while (TX_VALID && nv < 40) begin
            nv++;
            @(negedge CLK_1MHZ);
        end
        check("nom valid cycles", nv, FLEN);
        check("nom busy after", BUSY, 1'b0);
        lower_10hz();
        wait_idle("nom");
        cyc(3);

        // Backpressure: same payload, seq 01, ready pattern 1,0,0,1,0,1...
        TX_READY = 1'b0;
        exp_q.push_back(8'hEB); exp_q.push_back(8'h90);
        exp_q.push_back(8'h01); exp_q.push_back(8'h23); exp_q.push_back(8'h45);
        exp_q.push_back(8'h67); exp_q.push_back(8'h89); exp_q.push_back(8'hAB);
        exp_q.push_back(8'hCD); exp_q.push_back(8'hEF); exp_q.push_back(8'h00);
        exp_q.push_back(8'h11); exp_q.push_back(8'h01);
`ifdef GEIG_PKT_CSUM_EN
        exp_q.push_back(8'h10);
`endif
        raise_10hz();
        wait_valid("bp start");
        lower_10hz();
        for (int i = 0; i < 200 && BUSY; i++) begin
            TX_READY = pat[i % 6];
            cyc(1);
        end
        TX_READY = 1'b1;
        wait_idle("bp");
        cyc(3);

        // Drops: stall a frame across two more trigger rises, change data.
        d1 = 80'hDEADBEEFCAFEF00D1357;
        G_DATA_STACK = d1;
        TX_READY = 1'b0;
        push_frame(d1, 8'h02);
        raise_10hz();
        wait_valid("drop start");
        cyc(1);
        G_DATA_STACK = ~d1;
        lower_10hz();
        cyc(3);
        raise_10hz();
        cyc(4);
        lower_10hz();
        cyc(3);
        raise_10hz();
        cyc(4);
        lower_10hz();
        cyc(4);
        check("drop count", DROP_CNT, 8'h02);
        check("drop still busy", BUSY, 1'b1);
        TX_READY = 1'b1;
        wait_idle("drop");
        check("drop count after", DROP_CNT, 8'h02);
        cyc(3);

        // Reset after the 5th byte: valid falls asynchronously.
        d2 = 80'h112233445566778899AA;
        G_DATA_STACK = d2;
        TX_READY = 1'b1;
        exp_q.push_back(8'hEB); exp_q.push_back(8'h90);
        exp_q.push_back(8'h11); exp_q.push_back(8'h22); exp_q.push_back(8'h33);
        raise_10hz();
        wait_valid("mid start");
        nx = 0;
        for (int i = 0; i < 40; i++) begin
            if (TX_VALID && TX_READY) nx++;
            if (nx == 5) break;
            @(negedge CLK_1MHZ);
        end
        @(posedge CLK_1MHZ);
        #1;
        TX_READY = 1'b0;
        CLK_10HZ = 1'b0;
        check("mid valid before rst", TX_VALID, 1'b1);
        #1;
        RESET = 1'b0;
        #1;
        check("mid valid in rst", TX_VALID, 1'b0);
        check("mid busy in rst", BUSY, 1'b0);
        check("mid data in rst", TX_DATA, 8'h00);
        check("mid drop in rst", DROP_CNT, 8'h00);
        check("mid bytes sent", exp_q.size(), 0);
        cyc(3);
        RESET = 1'b1;
        cyc(3);
        check("mid no resume", TX_VALID, 1'b0);
        TX_READY = 1'b1;
        push_frame(d2, 8'h00);
        raise_10hz();
        wait_valid("mid restart");
        lower_10hz();
        wait_idle("mid restart");
        cyc(2);

        // Wrap: from reset, 257 frames, seq 00..FF then 00.
        RESET = 1'b0;
        cyc(2);
        RESET = 1'b1;
        cyc(3);
        TX_READY = 1'b1;
        for (int f = 0; f < 257; f++) begin
            b = 8'(f * 7 + 3);
            G_DATA_STACK = {10{b}} ^ 80'h0123456789ABCDEF0011;
            push_frame(G_DATA_STACK, 8'(f));
            raise_10hz();
            cyc(3);
            CLK_10HZ = 1'b0;
            wait_idle($sformatf("wrap %0d", f));
            cyc(1);
        end
        check("wrap drop", DROP_CNT, 8'h00);

        check("final pending", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/geig_packet_tx.md
GEIG_PACKET_TX -- requirements
Module: geig_packet_tx

Interface
REQ-001 Parameter SYNC0, default 8'hEB: first frame sync byte.
REQ-002 Parameter SYNC1, default 8'h90: second frame sync byte.
REQ-003 CLK_1MHZ  input  1  sole clock; all flops on rising edge.
REQ-004 RESET  input  1  asynchronous, active-low reset (0 = reset).
REQ-005 CLK_10HZ  input  1  frame trigger level from the 10 Hz divider; treated as data, not a clock.
REQ-006 G_DATA_STACK  input  80  geiger data stack from the data-handling stage.
REQ-007 TX_READY  input  1  downstream ready.
REQ-008 TX_DATA  output  8  current frame byte.
REQ-009 TX_VALID  output  1  TX_DATA valid.
REQ-010 BUSY  output  1  high from frame latch until the last byte is accepted.
REQ-011 DROP_CNT  output  8  count of triggers dropped while BUSY, saturating.

Function
REQ-012 CLK_10HZ SHALL pass through a 2-flop synchronizer plus a previous-value flop; trigger = sync2 & ~prev, one cycle wide.
REQ-013 On trigger in IDLE, G_DATA_STACK SHALL be latched into an 80-bit frame buffer, BUSY SHALL assert, and TX_VALID SHALL assert the next cycle with TX_DATA=SYNC0.
REQ-014 FSM states: IDLE, SYNC (2 bytes), PAYLOAD (10 bytes), SEQ (1 byte), CSUM (1 byte); advance only on a TX_VALID&TX_READY transfer.
REQ-015 Frame order: SYNC0, SYNC1, buffer[79:72] ... buffer[7:0] (MSB byte first), seq, checksum.
REQ-016 TX_DATA SHALL hold stable while TX_VALID=1 and TX_READY=0.
REQ-017 Back-to-back transfers are allowed; a 14-byte frame with TX_READY held at 1 SHALL take exactly 14 cycles of TX_VALID.
REQ-018 After the final transfer the FSM SHALL return to IDLE, with TX_VALID=0 and BUSY=0 for at least one cycle.
REQ-019 The checksum SHALL be the XOR of the 10 payload bytes and the seq byte; sync bytes are excluded.
REQ-020 The 8-bit seq counter SHALL increment once per completed frame and wrap 8'hFF->8'h00.
REQ-021 A trigger while BUSY SHALL be dropped: DROP_CNT+1, saturating at 8'hFF; the frame in flight is unaffected.
REQ-022 G_DATA_STACK changes while BUSY SHALL NOT affect the frame in flight.
REQ-023 If a trigger and the final transfer occur in the same cycle, the trigger SHALL count as dropped.

Reset
REQ-024 While RESET=0: TX_DATA=8'h00, TX_VALID=0, BUSY=0, DROP_CNT=0, seq=0, buffer=0, synchronizer flops=0, FSM=IDLE.
REQ-025 Reset mid-frame SHALL abort the frame immediately and asynchronously; no partial frame resumes after release.

Configuration
REQ-026 Macro GEIG_PKT_CSUM_EN defined: the CSUM state exists and frames are 14 bytes.
REQ-027 Macro GEIG_PKT_CSUM_EN undefined: CSUM state and checksum logic are removed; frames are 13 bytes ending at seq.

Structure
REQ-028 Package geig_pkt_pkg SHALL hold: the FSM state typedef, PAYLOAD_BYTES=10, and FRAME_LEN (14 or 13, selected by the macro).
REQ-029 Sub-module geig_trig_sync SHALL implement the synchronizer and edge detect (REQ-012).

Verification
REQ-030 Reset: hold RESET=0 with CLK_10HZ toggling -> all outputs 0, no TX_VALID.
REQ-031 Nominal: G_DATA_STACK=80'h0123456789ABCDEF0011, TX_READY=1, one CLK_10HZ rise -> EB 90 01 23 45 67 89 AB CD EF 00 11 00 11 on 14 consecutive cycles; BUSY then 0.
REQ-032 Backpressure: TX_READY pattern 1,0,0,1,0,1... during a frame -> TX_DATA held during stalls; byte sequence matches REQ-031 with no loss or duplication.
REQ-033 Drop: TX_READY=0 stalls a frame across 2 CLK_10HZ rises; G_DATA_STACK changed mid-frame -> DROP_CNT=2; frame bytes unchanged.
REQ-034 Wrap: 257 frames -> seq bytes ...FE, FF, 00; checksum matches seq in each frame; DROP_CNT=0.
REQ-035 Reset mid-frame: RESET=0 after the 5th byte -> TX_VALID falls with no clock edge; the next frame starts EB with seq 00.
